// File: rtl/gs_div_ctrl_if.sv
// Issue-side handshake and Q8.8 result bus of the Goldschmidt divider controller.
// The master is the arithmetic-unit issue logic; the slave is gs_div_ctrl.
interface gs_div_ctrl_if;
  logic               start;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic               busy;
  logic               done;
  logic        [15:0] q;
  logic               ovf;
  logic               dz;

  modport master (output start, a, b, input busy, done, q, ovf, dz);
  modport slave  (input start, a, b, output busy, done, q, ovf, dz);
endinterface

// File: rtl/gs_div_ctrl.sv
// Sequential Goldschmidt divider: signed 8-bit a/b -> signed Q8.8 quotient on one shared multiplier.
// Optional build macro GS_ROUND_EN rounds the final quotient to nearest instead of truncating.
module gs_div_ctrl #(
  parameter int ITERS = 4,
  parameter int FW    = 16
) (
  input  logic         clk,
  input  logic         rst,
  gs_div_ctrl_if.slave bus
);

  localparam int NW  = FW + 8;  // N: unsigned Q8.FW
  localparam int DW  = FW;      // D: unsigned Q0.FW, kept in [0.5, 1)
  localparam int FFW = FW + 2;  // F: unsigned Q2.FW
  localparam int PW  = NW + FFW;
  localparam int SW  = PW - FW;
  localparam int CW  = $clog2(ITERS + 1);
`ifdef GS_ROUND_EN
  localparam int RND_HALF = 1 << (FW - 9);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_MUL_N,
    S_MUL_D,
    S_FINAL,
    S_DONE
  } state_t;

  state_t          state, state_nx;

  logic            a_neg;
  logic            sign;
  logic [7:0]      mag_a;
  logic [7:0]      mag_b;
  logic [NW-1:0]   n_r;
  logic [DW-1:0]   d_r;
  logic [FFW-1:0]  f_r;
  logic [CW-1:0]   iter;
  logic [15:0]     q_r;
  logic            ovf_r;
  logic            dz_r;
  logic            busy;
  logic            done;

  logic [2:0]      shift;
  logic [7:0]      b_sh;
  logic [14:0]     a_sh;
  logic [NW-1:0]   n_norm;
  logic [DW-1:0]   d_norm;
  logic [FFW-1:0]  f_new;
  logic [NW-1:0]  mul_x;
  logic [FFW-1:0] mul_f;
  logic [SW-1:0]   prod_sh;
  logic [16:0]     m_val;
  logic [15:0]     q_calc;
  logic            ovf_calc;

  function automatic logic [2:0] lzc8(input logic [7:0] v);
    lzc8 = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) lzc8 = 3'(7 - i);
    end
  endfunction

  // Normalisation puts the divisor's leading one at bit 7 so D lands in [0.5, 1).
  always_comb begin
    shift  = lzc8(mag_b);
    b_sh   = mag_b << shift;
    a_sh   = 15'(mag_a) << shift;
    n_norm = NW'(a_sh) << (FW - 8);
    d_norm = DW'(b_sh) << (FW - 8);
  end

  // One multiplier serves both steps: N*F in MUL_N (F fresh from D), D*F in MUL_D (F from register).
  always_comb begin
    f_new   = {2'b10, {FW{1'b0}}} - {2'b00, d_r};
    mul_x   = (state == S_MUL_N) ? n_r   : NW'(d_r);
    mul_f   = (state == S_MUL_N) ? f_new : f_r;
    prod_sh = SW'((PW'(mul_x) * PW'(mul_f)) >> FW);
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    m_val    = '0;
    q_calc   = '0;
    ovf_calc = 1'b0;
`ifdef GS_ROUND_EN
    m_val = 17'(({1'b0, n_r} + (NW + 1)'(RND_HALF)) >> (FW - 8));
`else
    m_val = 17'(n_r >> (FW - 8));
`endif
    if (dz_r) begin
      q_calc = a_neg ? 16'h8000 : 16'h7FFF;
    end else if (!sign && (m_val > 17'h07FFF)) begin
      q_calc   = 16'h7FFF;
      ovf_calc = 1'b1;
    end else if (sign) begin
      q_calc = 16'(17'd0 - m_val);
    end else begin
      q_calc = m_val[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_NORM;
      S_NORM:  state_nx = (mag_b == 8'd0) ? S_FINAL : S_MUL_N;
      S_MUL_N: state_nx = S_MUL_D;
      S_MUL_D: state_nx = (int'(iter) + 1 < ITERS) ? S_MUL_N : S_FINAL;
      S_FINAL: state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_neg <= 1'b0;
      sign  <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      n_r   <= '0;
      d_r   <= '0;
      f_r   <= '0;
      iter  <= '0;
      q_r   <= '0;
      ovf_r <= 1'b0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          a_neg <= bus.a[7];
          sign  <= bus.a[7] ^ bus.b[7];
          mag_a <= bus.a[7] ? 8'(-bus.a) : bus.a;
          mag_b <= bus.b[7] ? 8'(-bus.b) : bus.b;
          ovf_r <= 1'b0;
          dz_r  <= 1'b0;
        end
        S_NORM: begin
          if (mag_b == 8'd0) begin
            dz_r <= 1'b1;
          end else begin
            n_r  <= n_norm;
            d_r  <= d_norm;
            iter <= '0;
          end
        end
        S_MUL_N: begin
          n_r <= prod_sh[NW-1:0];
          f_r <= f_new;
        end
        S_MUL_D: begin
          d_r  <= prod_sh[DW-1:0];
          iter <= iter + 1'b1;
        end
        S_FINAL: begin
          q_r   <= q_calc;
          ovf_r <= ovf_calc;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.q    = q_r;
  assign bus.ovf  = ovf_r;
  assign bus.dz   = dz_r;

  // Convergence keeps N below 256 and D below 1, so the shifted products never spill.
  assert property (@(posedge clk) disable iff (rst)
    (state == S_MUL_N) |-> (prod_sh[SW-1:NW] == '0));
  assert property (@(posedge clk) disable iff (rst)
    (state == S_MUL_D) |-> (prod_sh[SW-1:DW] == '0));

endmodule

// File: doc/gs_div_ctrl.md
Name: gs_div_ctrl

Overview:
Sequential Goldschmidt divider controller for signed 8-bit operands, producing a signed Q8.8 quotient.
- Normalizes the divisor, then runs ITERS refinement steps N*=F, D*=F with F=2-D.
- All multiplies go through one shared, time-multiplexed multiplier, so no per-step multipliers are needed.
- Fixes sign, saturation and divide-by-zero at the end.
- Sits between the arithmetic-unit issue logic (start/done handshake) and the Q8.8 result bus.

Parameters:
ITERS, 4, number of Goldschmidt iterations (1..6)
FW, 16, fractional bits of internal N/D/F registers

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  8  signed dividend
b  input  8  signed divisor
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse; q/ovf/dz valid from this cycle until next accepted start
q  output  16  signed Q8.8 quotient
ovf  output  1  positive result saturated
dz  output  1  divide by zero

Behaviour:
- One clock (clk). Reset asynchronous, active-high (rst); on assertion:
  - state=IDLE.
  - busy=0, done=0, q=0, ovf=0, dz=0.
  - Internal registers cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE -> NORM -> (MUL_N -> MUL_D) x ITERS -> FINAL -> DONE -> IDLE.
  - Every state lasts exactly one cycle except IDLE.
- IDLE:
  - On start=1, latch a, b, sign = a[7]^b[7], |a|, |b| as 8-bit unsigned (128 allowed).
  - Go to NORM.
- NORM:
  - If |b|==0: set dz, go to FINAL.
  - Else s = leading-zero count of |b| (0..7).
  - D = (|b|<<s) as Q0.FW in [0.5,1).
  - N = (|a|<<s)/256 as Q8.FW.
  - Iteration counter = 0.
- MUL_N:
  - F = 2.0 - D (Q2.FW).
  - Shared multiplier computes N*F; N <= product>>FW (truncate). F is held in a register.
- MUL_D:
  - Shared multiplier computes D*F; D <= product>>FW.
  - Increment counter; go to MUL_N if counter<ITERS, else FINAL.
- FINAL:
  - M = N truncated to unsigned Q8.8 (17 bits max).
  - dz: q = 0x8000 if a<0, else 0x7FFF.
  - Else if sign=0 and M>0x7FFF: q=0x7FFF, ovf=1.
  - Else q = sign ? -M : M.
- DONE: done=1 for exactly this cycle, then IDLE.
- Flags ovf/dz cleared when the next start is accepted.
- Latency, accepting edge -> done-high cycle:
  - 2*ITERS+3 cycles (11 at default).
  - 3 cycles for dz.
- start while busy is ignored, not queued.
- start in the DONE cycle is ignored; earliest restart is the cycle after done.
- Multiplier widths: N is Q8.FW (24 bits); F is Q2.FW (18 bits); product is 42 bits before shift.
- Upper bits beyond N width must be zero by construction. The verifier asserts this.
- a=0 gives q=0 with no flags.

Optional Feature:
Macro GS_ROUND_EN.
- Defined: FINAL rounds to nearest, M = (N + 2^(FW-9)) >> (FW-8), before saturation/sign.
- Undefined: truncation.
- Latency is identical in both builds.

Test Plan:
- Reset, then start with a=100, b=4 -> done 11 cycles after accept; q within ±1 LSB of 0x1900; ovf=0, dz=0.
- a=-128, b=-1 -> q=0x7FFF, ovf=1.
- a=-128, b=1 -> q=0x8000 (±1 LSB), ovf=0.
- a=5, b=0 -> done 3 cycles after accept, q=0x7FFF, dz=1.
- a=-5, b=0 -> q=0x8000, dz=1.
- a=7, b=-3 -> q within ±1 LSB of -2.3333 (0xFDAB), busy high for 11 cycles.
  - start pulsed mid-operation is ignored: exactly one done.
  - Second start in the cycle after done is accepted with fresh a/b.
- Assert rst during MUL_D of a 100/4 run -> all outputs 0 immediately (before next edge), no done.
  - Then a=1, b=3 completes with q within ±1 LSB of 0x0055.
  - With GS_ROUND_EN this case gives exactly 0x0055.
